// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory fetch bus: request/address out, valid/data back.
interface fetch_pc_unit_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;

    modport master (output imem_req, output imem_addr, input imem_valid, input imem_data);
    modport slave  (input imem_req, input imem_addr, output imem_valid, output imem_data);
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch stage of the 16-bit core: owns the PC, fetches over the imem handshake,
// presents one instruction per EXEC cycle and resolves the next PC.
module fetch_pc_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          MAX_WAIT = 15,
    parameter int          CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    fetch_pc_unit_if.master    imem,
    output logic [15:0]        instr,
    output logic               instr_valid,
    output logic [15:0]        pc,
    output logic [15:0]        pc_plus2,
    input  logic               branch,
    input  logic               branch_reg,
    input  logic [2:0]         cond,
    input  logic [15:0]        imm_dec,
    input  logic [15:0]        rs_data,
    input  logic               flag_z,
    input  logic               flag_v,
    input  logic               flag_n,
    input  logic               hlt,
    output logic               halted,
    output logic               fetch_err,
    output logic [CNT_W-1:0]   retire_cnt
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt, wait_inc;
    logic              ld_instr, ld_pc, retire, set_err;
    logic              taken;
    logic [15:0]       next_pc;

    assign pc_plus2 = pc + 16'd2;
    assign wait_inc = wait_cnt + 1'b1;

    always_comb begin
        taken = 1'b0;
        case (cond)
            3'b000: taken = !flag_z;
            3'b001: taken = flag_z;
            3'b010: taken = !flag_z && !flag_n;
            3'b011: taken = flag_n;
            3'b100: taken = flag_z || (!flag_z && !flag_n);
            3'b101: taken = flag_n || flag_z;
            3'b110: taken = flag_v;
            default: taken = 1'b1;
        endcase
    end

    always_comb begin
        next_pc = pc_plus2;
        if (branch && taken)
            next_pc = branch_reg ? rs_data : pc_plus2 + imm_dec;
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        ld_instr  = 1'b0;
        ld_pc     = 1'b0;
        retire    = 1'b0;
        set_err   = 1'b0;
        case (state)
            FETCH: begin
                if (imem.imem_valid) begin
                    ld_instr  = 1'b1;
                    wait_nxt  = '0;
                    state_nxt = EXEC;
                end else if (wait_inc == WAIT_W'(MAX_WAIT)) begin
                    // MAX_WAIT consecutive empty FETCH cycles: give up
                    set_err   = 1'b1;
                    wait_nxt  = '0;
                    state_nxt = HALT;
                end else begin
                    wait_nxt = wait_inc;
                end
            end
            EXEC: begin
                retire = 1'b1;
                if (hlt) begin
                    state_nxt = HALT;
                end else begin
                    ld_pc     = 1'b1;
                    state_nxt = FETCH;
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            instr      <= 16'h0000;
            wait_cnt   <= '0;
            fetch_err  <= 1'b0;
            retire_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (ld_instr) instr <= imem.imem_data;
            if (ld_pc)    pc    <= {next_pc[15:1], 1'b0};
            if (retire)   retire_cnt <= retire_cnt + 1'b1;
            if (set_err)  fetch_err  <= 1'b1;
        end
    end

    // Request is held off while reset is asserted; never depends on imem_valid.
    assign imem.imem_req  = (state == FETCH) && !rst;
    assign imem.imem_addr = pc;
    assign instr_valid    = (state == EXEC);
    assign halted         = (state == HALT);
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: branch-resolution table plus handshake,
// timeout, halt and reset sequences.
module tb_fetch_pc_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr, pc, pc_plus2, imm_dec, rs_data;
    logic        instr_valid, branch, branch_reg, flag_z, flag_v, flag_n, hlt;
    logic        halted, fetch_err;
    logic [2:0]  cond;
    logic [15:0] retire_cnt;
    int          passed = 0, total = 0;

    fetch_pc_unit_if bus();

    fetch_pc_unit dut (
        .clk(clk), .rst(rst), .imem(bus.master), .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .pc_plus2(pc_plus2), .branch(branch), .branch_reg(branch_reg), .cond(cond),
        .imm_dec(imm_dec), .rs_data(rs_data), .flag_z(flag_z), .flag_v(flag_v),
        .flag_n(flag_n), .hlt(hlt), .halted(halted), .fetch_err(fetch_err),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] start;
        logic        br, brr;
        logic [2:0]  cnd;
        logic        z, v, n;
        logic [15:0] imm, rs, exp_pc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic clr_dec();
        branch = 0; branch_reg = 0; cond = 0; imm_dec = 0; rs_data = 0;
        flag_z = 0; flag_v = 0; flag_n = 0; hlt = 0;
    endtask

    // Assert reset for one edge, check reset outputs, release.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        bus.imem_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_pc"}, {16'h0, pc}, 32'h0);
        chk({tag, "_req"}, {31'h0, bus.imem_req}, 32'h0);
        chk({tag, "_ivalid"}, {31'h0, instr_valid}, 32'h0);
        chk({tag, "_halted"}, {31'h0, halted}, 32'h0);
        chk({tag, "_err"}, {31'h0, fetch_err}, 32'h0);
        chk({tag, "_retire"}, {16'h0, retire_cnt}, 32'h0);
        chk({tag, "_instr"}, {16'h0, instr}, 32'h0);
        rst = 1'b0;
        #1;
    endtask

    // Starting at a negedge in FETCH: miss `delay` cycles, then return data.
    // Ends at the negedge inside EXEC; held counts cycles with stable req/addr.
    task automatic fetch(input int delay, input logic [15:0] data, output int held);
        logic [15:0] a;
        a = bus.imem_addr;
        held = 0;
        for (int i = 0; i <= delay; i++) begin
            if (bus.imem_req && bus.imem_addr == a) held++;
            bus.imem_valid = (i == delay);
            bus.imem_data  = (i == delay) ? data : 16'hDEAD;
            @(negedge clk);
        end
        bus.imem_valid = 1'b0;
        bus.imem_data  = 16'hDEAD;
    endtask

    task automatic jump_to(input logic [15:0] addr);
        int h;
        clr_dec();
        branch = 1; branch_reg = 1; cond = 3'b111; rs_data = addr;
        fetch(0, 16'hF000, h);
        @(negedge clk);
        clr_dec();
        chk("jump_pc", {16'h0, pc}, {16'h0, addr});
    endtask

    vec_t vt[13];
    int   h, reqs;

    initial begin
        vt[0]  = '{16'h0010, 1, 0, 3'b001, 1, 0, 0, 16'hFFFC, 16'h0, 16'h000E};
        vt[1]  = '{16'h0010, 1, 0, 3'b001, 0, 0, 0, 16'hFFFC, 16'h0, 16'h0012};
        vt[2]  = '{16'h0010, 1, 0, 3'b111, 0, 0, 0, 16'h0010, 16'h0, 16'h0022};
        vt[3]  = '{16'h0010, 1, 1, 3'b111, 1, 1, 1, 16'h0000, 16'h1235, 16'h1234};
        vt[4]  = '{16'h0100, 1, 0, 3'b000, 0, 0, 0, 16'h0004, 16'h0, 16'h0106};
        vt[5]  = '{16'h0100, 1, 0, 3'b010, 0, 0, 1, 16'h0004, 16'h0, 16'h0102};
        vt[6]  = '{16'h0100, 1, 0, 3'b100, 1, 0, 0, 16'h0008, 16'h0, 16'h010A};
        vt[7]  = '{16'h0100, 1, 0, 3'b101, 0, 0, 0, 16'h0008, 16'h0, 16'h0102};
        vt[8]  = '{16'h0100, 1, 0, 3'b110, 0, 1, 0, 16'hFFFE, 16'h0, 16'h0100};
        vt[9]  = '{16'h0100, 1, 0, 3'b011, 0, 0, 1, 16'h0020, 16'h0, 16'h0122};
        vt[10] = '{16'hFFFE, 0, 0, 3'b111, 0, 0, 0, 16'h0040, 16'h0, 16'h0000};
        vt[11] = '{16'h0100, 0, 1, 3'b111, 0, 0, 0, 16'h0000, 16'h4444, 16'h0102};
        vt[12] = '{16'h0100, 1, 0, 3'b100, 0, 0, 1, 16'h0008, 16'h0, 16'h0102};

        clr_dec();
        bus.imem_valid = 0;
        bus.imem_data  = 16'h0;

        // Zero-wait fetch of LLB from reset
        do_reset("rst1");
        fetch(0, 16'hB1AA, h);
        chk("t1_held", h, 1);
        chk("t1_ivalid", {31'h0, instr_valid}, 1);
        chk("t1_instr", {16'h0, instr}, 32'hB1AA);
        chk("t1_req_exec", {31'h0, bus.imem_req}, 0);
        @(negedge clk);
        chk("t1_pc", {16'h0, pc}, 32'h0002);
        chk("t1_pc_plus2", {16'h0, pc_plus2}, 32'h0004);
        chk("t1_retire", {16'h0, retire_cnt}, 1);
        chk("t1_ivalid_off", {31'h0, instr_valid}, 0);

        // Next-PC resolution table
        for (int i = 0; i < 13; i++) begin
            jump_to(vt[i].start);
            branch = vt[i].br; branch_reg = vt[i].brr; cond = vt[i].cnd;
            flag_z = vt[i].z; flag_v = vt[i].v; flag_n = vt[i].n;
            imm_dec = vt[i].imm; rs_data = vt[i].rs;
            fetch(0, 16'hC000, h);
            @(negedge clk);
            chk($sformatf("vec%0d_pc", i), {16'h0, pc}, {16'h0, vt[i].exp_pc});
            clr_dec();
        end

        // Delayed valid: req/addr held 4 cycles, then exactly one EXEC
        do_reset("rst4");
        fetch(3, 16'h1234, h);
        chk("t4_held", h, 4);
        chk("t4_ivalid", {31'h0, instr_valid}, 1);
        chk("t4_instr", {16'h0, instr}, 32'h1234);
        @(negedge clk);
        chk("t4_one_exec", {31'h0, instr_valid}, 0);
        // Valid on the last allowed cycle still succeeds
        fetch(14, 16'h5678, h);
        chk("t4_long_held", h, 15);
        chk("t4_long_ivalid", {31'h0, instr_valid}, 1);
        chk("t4_long_noerr", {31'h0, fetch_err}, 0);
        @(negedge clk);
        // Timeout
        reqs = 0;
        for (int i = 0; i < 40 && !halted; i++) begin
            if (bus.imem_req) reqs++;
            @(negedge clk);
        end
        chk("t4_to_reqs", reqs, 15);
        chk("t4_to_err", {31'h0, fetch_err}, 1);
        chk("t4_to_halted", {31'h0, halted}, 1);
        chk("t4_to_req", {31'h0, bus.imem_req}, 0);

        // HLT (with simultaneous branch) at 0020
        do_reset("rst5");
        jump_to(16'h0020);
        hlt = 1; branch = 1; cond = 3'b111; imm_dec = 16'h0100;
        fetch(0, 16'hF000, h);
        @(negedge clk);
        clr_dec();
        chk("t5_halted", {31'h0, halted}, 1);
        chk("t5_pc", {16'h0, pc}, 32'h0020);
        chk("t5_retire", {16'h0, retire_cnt}, 2);
        reqs = 0;
        for (int i = 0; i < 5; i++) begin
            bus.imem_valid = 1'b1;
            if (bus.imem_req || instr_valid) reqs++;
            @(negedge clk);
        end
        bus.imem_valid = 1'b0;
        chk("t5_no_req", reqs, 0);
        chk("t5_still_halted", {31'h0, halted}, 1);
        do_reset("rst5b");
        chk("t5_resume_req", {31'h0, bus.imem_req}, 1);
        chk("t5_resume_addr", {16'h0, bus.imem_addr}, 32'h0000);

        // Reset in the middle of a FETCH wait clears wait counter too
        jump_to(16'h0040);
        for (int i = 0; i < 3; i++) @(negedge clk);
        do_reset("rst6");
        fetch(14, 16'hABCD, h);
        chk("t6_held", h, 15);
        chk("t6_noerr", {31'h0, fetch_err}, 0);
        chk("t6_ivalid", {31'h0, instr_valid}, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
